// File: rtl/painter_pkg.sv
// painter_pkg: shared constants, state encoding and helpers for frame_painter.
//   - Default VGA geometry, address/colour/data widths, command field widths.
//   - state_t: IDLE/DRAW always; CLEAR only when FRAME_PAINTER_CLEAR_EN is defined.
//   - pack_pixel: places a colour in the low bits of a frame-buffer word.
//   - row_base_of: y*width built from shifted adds of the constant width.
package painter_pkg;

  localparam int unsigned DEF_VGA_WIDTH  = 640;
  localparam int unsigned DEF_VGA_HEIGHT = 480;

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned COLOR_W = 2;
  localparam int unsigned DATA_W  = 24;

  // Command field widths and their one-bit-wider clip-sum widths.
  localparam int unsigned X_W  = 10;
  localparam int unsigned Y_W  = 9;
  localparam int unsigned XS_W = X_W + 1;
  localparam int unsigned YS_W = Y_W + 1;

`ifdef FRAME_PAINTER_CLEAR_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1
  } state_t;
`endif

  function automatic logic [DATA_W-1:0] pack_pixel(input logic [COLOR_W-1:0] color);
    return {{(DATA_W - COLOR_W){1'b0}}, color};
  endfunction

  // y times a constant width, expanded into one shifted add per set bit of the
  // width so no general multiplier is built.
  function automatic logic [ADDR_W-1:0] row_base_of(input logic [Y_W-1:0] y,
                                                    input int unsigned width);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (width[i]) acc = acc + (ADDR_W'(y) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rect_clip.sv
// rect_clip: combinational clipping of a draw rectangle to the visible screen.
// Ports:
//   x, y     - rectangle top-left corner
//   w, h     - rectangle width / height
//   x_end    - min(x+w, VGA_WIDTH), exclusive column bound
//   y_end    - min(y+h, VGA_HEIGHT), exclusive row bound
//   empty    - nothing visible remains after clipping
module rect_clip
  import painter_pkg::*;
#(
  parameter int unsigned VGA_WIDTH  = DEF_VGA_WIDTH,
  parameter int unsigned VGA_HEIGHT = DEF_VGA_HEIGHT
) (
  input  logic [X_W-1:0]  x,
  input  logic [Y_W-1:0]  y,
  input  logic [X_W-1:0]  w,
  input  logic [Y_W-1:0]  h,
  output logic [XS_W-1:0] x_end,
  output logic [YS_W-1:0] y_end,
  output logic            empty
);

  localparam logic [XS_W-1:0] X_LIM = XS_W'(VGA_WIDTH);
  localparam logic [YS_W-1:0] Y_LIM = YS_W'(VGA_HEIGHT);

  logic [XS_W-1:0] x_sum;
  logic [YS_W-1:0] y_sum;

  always_comb begin
    // Sums carry one extra bit so large corners plus large sizes never wrap.
    x_sum = {1'b0, x} + {1'b0, w};
    y_sum = {1'b0, y} + {1'b0, h};
    x_end = (x_sum > X_LIM) ? X_LIM : x_sum;
    y_end = (y_sum > Y_LIM) ? Y_LIM : y_sum;
    empty = (w == '0) || (h == '0) || ({1'b0, x} >= X_LIM) || ({1'b0, y} >= Y_LIM);
  end

endmodule

// File: rtl/frame_painter.sv
// frame_painter: fills clipped rectangles (and optionally the whole frame) in a
// frame buffer, one pixel per clock in raster order.
// Ports:
//   WRITE_CLK   - block clock, also the frame-buffer write clock
//   RESET       - synchronous, active-high
//   CMD_VALID / CMD_READY - command handshake, ready only while idle
//   CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOR - rectangle command fields
//   CMD_CLEAR   - full-frame fill with colour 0 (FRAME_PAINTER_CLEAR_EN builds only)
//   WRITE_ADDR  - y*VGA_WIDTH+x
//   WRITE_DATA  - {22'b0, colour}
//   WRITE_EN    - pixel write strobe
//   BUSY        - a command is in progress
// Config macro: FRAME_PAINTER_CLEAR_EN adds the CLEAR state, CMD_CLEAR handling and
// an automatic frame clear after reset. Without it CMD_CLEAR is ignored.
module frame_painter
  import painter_pkg::*;
#(
  parameter int unsigned VGA_WIDTH  = DEF_VGA_WIDTH,
  parameter int unsigned VGA_HEIGHT = DEF_VGA_HEIGHT
) (
  input  logic               WRITE_CLK,
  input  logic               RESET,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [X_W-1:0]     CMD_X,
  input  logic [Y_W-1:0]     CMD_Y,
  input  logic [X_W-1:0]     CMD_W,
  input  logic [Y_W-1:0]     CMD_H,
  input  logic [COLOR_W-1:0] CMD_COLOR,
  input  logic               CMD_CLEAR,
  output logic [ADDR_W-1:0]  WRITE_ADDR,
  output logic [DATA_W-1:0]  WRITE_DATA,
  output logic               WRITE_EN,
  output logic               BUSY
);

`ifdef FRAME_PAINTER_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VGA_WIDTH * VGA_HEIGHT - 1);
`else
  logic clear_unused;
  assign clear_unused = CMD_CLEAR;
`endif

  state_t state, state_d;

  // Low for the first cycle after reset; gates CMD_READY and starts the
  // post-reset clear when that feature is built in.
  logic armed;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] row_base, row_base_d;
  logic [X_W-1:0]    col, col_d;
  logic [Y_W-1:0]    row, row_d;
  logic [X_W-1:0]    x_lo, x_lo_d;
  logic [XS_W-1:0]   x_end_q, x_end_d;
  logic [YS_W-1:0]   y_end_q, y_end_d;

  logic [XS_W-1:0]   clip_x_end;
  logic [YS_W-1:0]   clip_y_end;
  logic              clip_empty;

  logic [XS_W-1:0]   col_inc;
  logic [YS_W-1:0]   row_inc;
  logic              accept;

  rect_clip #(
    .VGA_WIDTH (VGA_WIDTH),
    .VGA_HEIGHT(VGA_HEIGHT)
  ) u_clip (
    .x    (CMD_X),
    .y    (CMD_Y),
    .w    (CMD_W),
    .h    (CMD_H),
    .x_end(clip_x_end),
    .y_end(clip_y_end),
    .empty(clip_empty)
  );

  assign CMD_READY  = (state == ST_IDLE) && armed;
  assign accept     = CMD_VALID && CMD_READY;
  assign WRITE_ADDR = addr_q;
  assign WRITE_DATA = data_q;
  assign WRITE_EN   = en_q;
  assign BUSY       = busy_q;

  always_comb begin
    state_d    = state;
    addr_d     = addr_q;
    data_d     = data_q;
    en_d       = 1'b0;
    row_base_d = row_base;
    col_d      = col;
    row_d      = row;
    x_lo_d     = x_lo;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    col_inc    = {1'b0, col} + XS_W'(1);
    row_inc    = {1'b0, row} + YS_W'(1);

    case (state)
      ST_IDLE: begin
`ifdef FRAME_PAINTER_CLEAR_EN
        if (!armed || (accept && CMD_CLEAR)) begin
          state_d = ST_CLEAR;
          addr_d  = '0;
          data_d  = '0;
          en_d    = 1'b1;
        end else
`endif
        if (accept) begin
          // Always pass through DRAW so an empty command still shows one busy cycle.
          state_d    = ST_DRAW;
          x_lo_d     = CMD_X;
          col_d      = CMD_X;
          row_d      = CMD_Y;
          x_end_d    = clip_x_end;
          y_end_d    = clip_y_end;
          row_base_d = row_base_of(CMD_Y, VGA_WIDTH);
          if (!clip_empty) begin
            en_d   = 1'b1;
            addr_d = row_base_d + ADDR_W'(CMD_X);
            data_d = pack_pixel(CMD_COLOR);
          end
        end
      end

      ST_DRAW: begin
        // en_q low here means the accepted command clipped to nothing.
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (col_inc < x_end_q) begin
          col_d  = col_inc[X_W-1:0];
          addr_d = row_base + ADDR_W'(col_inc);
          en_d   = 1'b1;
        end else if (row_inc < y_end_q) begin
          row_d      = row_inc[Y_W-1:0];
          col_d      = x_lo;
          row_base_d = row_base + ADDR_W'(VGA_WIDTH);
          addr_d     = row_base_d + ADDR_W'(x_lo);
          en_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

`ifdef FRAME_PAINTER_CLEAR_EN
      ST_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          en_d   = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge WRITE_CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      armed  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_d;
      armed  <= 1'b1;
      addr_q <= addr_d;
      data_q <= data_d;
      en_q   <= en_d;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge WRITE_CLK) begin
    row_base <= row_base_d;
    col      <= col_d;
    row      <= row_d;
    x_lo     <= x_lo_d;
    x_end_q  <= x_end_d;
    y_end_q  <= y_end_d;
  end

endmodule
